// File: rtl/micro_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : micro_sequencer_if
//  Description : Bundle of the micro-sequencer control, dispatch, microcode
//                load and control-word output signals.
//  Revision    : 1.0  initial release
// ============================================================================
interface micro_sequencer_if #(
  parameter int UADDR_W = 5,
  parameter int CW_W    = 36,
  parameter int OPC_W   = 6,
  parameter int CNT_W   = 5,
  parameter int LD_AW   = 6
);
  logic               run;
  logic               stall;
  logic [OPC_W-1:0]   opcode;
  logic [CNT_W-1:0]   hc_len;
  logic               ovf;
  logic               ld_en;
  logic [1:0]         ld_sel;
  logic [LD_AW-1:0]   ld_addr;
  logic [CW_W-1:0]    ld_data;
  logic [CW_W-1:0]    cw;
  logic [UADDR_W-1:0] state;
  logic               trap;
  logic               hc_busy;

  modport master (
    output run, stall, opcode, hc_len, ovf, ld_en, ld_sel, ld_addr, ld_data,
    input  cw, state, trap, hc_busy
  );

  modport slave (
    input  run, stall, opcode, hc_len, ovf, ld_en, ld_sel, ld_addr, ld_data,
    output cw, state, trap, hc_busy
  );
endinterface
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : micro_sequencer
//  Description : Microprogrammed control unit core. Writable control store,
//                three opcode dispatch tables, registered micro-PC with
//                fetch/sequential/dispatch/hold-count next-address selection,
//                stall, overflow trap and reserved-code trap.
//  Revision    : 1.0  initial release
// ============================================================================
module micro_sequencer #(
  parameter int UADDR_W   = 5,
  parameter int CW_W      = 36,
  parameter int NSEL_W    = 3,
  parameter int OPC_W     = 6,
  parameter int CNT_W     = 5,
  parameter int LD_AW     = 6,
  parameter int TRAP_ADDR = 30,
  parameter int INV_ADDR  = 31
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  micro_sequencer_if.slave   bus
);

  localparam int DEPTH    = 1 << UADDR_W;
  localparam int DT_DEPTH = 1 << OPC_W;

  localparam logic [UADDR_W-1:0] TRAP_A = UADDR_W'(TRAP_ADDR);
  localparam logic [UADDR_W-1:0] INV_A  = UADDR_W'(INV_ADDR);

  // next-address select encodings (codes above SEL_HC are reserved)
  localparam logic [NSEL_W-1:0] SEL_FETCH = NSEL_W'(0);
  localparam logic [NSEL_W-1:0] SEL_SEQ   = NSEL_W'(1);
  localparam logic [NSEL_W-1:0] SEL_DT1   = NSEL_W'(2);
  localparam logic [NSEL_W-1:0] SEL_DT2   = NSEL_W'(3);
  localparam logic [NSEL_W-1:0] SEL_DT3   = NSEL_W'(4);
  localparam logic [NSEL_W-1:0] SEL_HC    = NSEL_W'(5);

  // control store and dispatch tables; contents are loaded by software, not reset
  logic [CW_W-1:0]    store [DEPTH];
  logic [UADDR_W-1:0] dt1   [DT_DEPTH];
  logic [UADDR_W-1:0] dt2   [DT_DEPTH];
  logic [UADDR_W-1:0] dt3   [DT_DEPTH];

  logic [UADDR_W-1:0] upc;
  logic [UADDR_W-1:0] upc_next;
  logic [UADDR_W-1:0] upc_inc;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               busy;
  logic               busy_next;
  logic               trap_flag;
  logic               trap_next;
  logic [CW_W-1:0]    word;
  logic [NSEL_W-1:0]  sel;
  logic [LD_AW-1:0]   ld_index;

  assign ld_index = bus.ld_addr;
  assign word     = store[upc];
  assign sel      = word[NSEL_W-1:0];
  assign upc_inc  = upc + 1'b1;

  // microcode and dispatch-table writes, accepted every cycle regardless of run/stall
  always_ff @(posedge clk) begin
    if (bus.ld_en) begin
      case (bus.ld_sel)
        2'd0:    store[ld_index[UADDR_W-1:0]] <= bus.ld_data;
        2'd1:    dt1[ld_index[OPC_W-1:0]]     <= bus.ld_data[UADDR_W-1:0];
        2'd2:    dt2[ld_index[OPC_W-1:0]]     <= bus.ld_data[UADDR_W-1:0];
        default: dt3[ld_index[OPC_W-1:0]]     <= bus.ld_data[UADDR_W-1:0];
      endcase
    end
  end

  // state register: micro-PC, hold counter, repeat flag and trap pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      trap_flag <= 1'b0;
    end else begin
      upc       <= upc_next;
      cnt       <= cnt_next;
      busy      <= busy_next;
      trap_flag <= trap_next;
    end
  end

  // next-address logic: run > stall > overflow trap > select code
  always_comb begin
    upc_next  = upc;
    cnt_next  = cnt;
    busy_next = busy;
    trap_next = 1'b0;
    if (!bus.run) begin
      upc_next  = '0;
      cnt_next  = '0;
      busy_next = 1'b0;
    end else if (!bus.stall) begin
      // any non-stalled step that does not continue a repeat leaves it idle
      cnt_next  = '0;
      busy_next = 1'b0;
      if (bus.ovf && word[CW_W-1]) begin
        upc_next  = TRAP_A;
        trap_next = 1'b1;
      end else begin
        case (sel)
          SEL_FETCH: upc_next = '0;
          SEL_SEQ:   upc_next = upc_inc;
          SEL_DT1:   upc_next = dt1[bus.opcode];
          SEL_DT2:   upc_next = dt2[bus.opcode];
          SEL_DT3:   upc_next = dt3[bus.opcode];
          SEL_HC: begin
            if (!busy) begin
              // entry: zero length falls straight through, else latch the count
              if (bus.hc_len == '0) begin
                upc_next = upc_inc;
              end else begin
                cnt_next  = bus.hc_len;
                busy_next = 1'b1;
              end
            end else if (cnt == CNT_W'(1)) begin
              upc_next = upc_inc;
            end else begin
              cnt_next  = cnt - 1'b1;
              busy_next = 1'b1;
            end
          end
          default: begin
            upc_next  = INV_A;
            trap_next = 1'b1;
          end
        endcase
      end
    end
  end

  // outputs: control word masked while parked, registered status
  always_comb begin
    bus.cw      = bus.run ? word : '0;
    bus.state   = upc;
    bus.trap    = trap_flag;
    bus.hc_busy = busy;
  end

endmodule
`default_nettype wire
